move_sched: RTL

Consumer of the vertical and horizontal tick flags. On a vertical tick it queues a gravity drop. On a horizontal tick it samples the player buttons with delayed auto-shift (DAS), then issues one move command at a time to the board logic over a valid/ack handshake. It sits between the tick generator and the board/collision logic in `game`. It is the only source of piece-movement commands.

---
 rtl/tetris_pkg.sv | 20 ++
 rtl/move_sched_if.sv | 12 +
 rtl/move_das.sv | 42 ++++
 rtl/move_sched.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the tetris game blocks: move opcodes and scheduler defaults.
package tetris_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        DOWN  = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        ROT   = 3'd4,
        SOFT  = 3'd5
    } move_op_t;

    localparam int unsigned DAS_TICKS_DEFAULT = 4;

    // Ops whose collision means the piece has landed.
    function automatic logic is_drop(input move_op_t op);
        return (op == DOWN) || (op == SOFT);
    endfunction

endpackage

// File: rtl/move_sched_if.sv
// Move-command valid/ack channel between the scheduler and the board logic.
interface move_sched_if;
    import tetris_pkg::*;

    logic     cmd_valid;
    move_op_t cmd_op;
    logic     cmd_ack;
    logic     cmd_blocked;

    modport master (output cmd_valid, output cmd_op, input cmd_ack, input cmd_blocked);
    modport slave  (input cmd_valid, input cmd_op, output cmd_ack, output cmd_blocked);
endinterface

// File: rtl/move_das.sv
// Delayed auto-shift for one direction: fires on the first held sample,
// stays quiet for DAS_TICKS samples, then fires on every sample.
module move_das
    import tetris_pkg::*;
#(
    parameter int unsigned DAS_TICKS = DAS_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample,
    input  logic held,
    output logic fire_c
);
    localparam int unsigned CW = (DAS_TICKS < 1) ? 1 : $clog2(DAS_TICKS + 1);

    logic          held_q;
    logic [CW-1:0] cnt_q;

    assign fire_c = held & (~held_q | (cnt_q == CW'(DAS_TICKS)));

    // Hold counter saturates at DAS_TICKS; any release restarts the sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clr) begin
            held_q <= 1'b0;
            cnt_q  <= '0;
        end else if (sample) begin
            if (!held) begin
                held_q <= 1'b0;
                cnt_q  <= '0;
            end else if (!held_q) begin
                held_q <= 1'b1;
                cnt_q  <= '0;
            end else if (cnt_q != CW'(DAS_TICKS)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/move_sched.sv
// Piece-movement scheduler: turns gravity and input-sample ticks into one
// board command at a time. MOVE_SCHED_SOFTDROP_EN enables SOFT from btn_down.
module move_sched
    import tetris_pkg::*;
#(
    parameter int unsigned DAS_TICKS = DAS_TICKS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ticking,
    input  logic         vertical_flag,
    input  logic         horizontal_flag,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_rot,
    input  logic         btn_down,
    move_sched_if.master cmd,
    output logic         lock_pulse,
    output logic         overrun
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t   state_q, state_d;
    logic     valid_q, valid_d;
    move_op_t op_q, op_d;
    logic     lock_d;
    logic     v_pend, h_pend, rot_prev;
    move_op_t h_op;
    move_op_t sample_op_c;
    logic     left_fire_c, right_fire_c;
    logic     xfer_c, down_xfer_c, h_xfer_c;
    logic     soft_req_c;

`ifdef MOVE_SCHED_SOFTDROP_EN
    assign soft_req_c = btn_down;
`else
    logic unused_btn_down;
    assign soft_req_c      = 1'b0;
    assign unused_btn_down = btn_down;
`endif

    assign xfer_c      = valid_q & cmd.cmd_ack;
    assign down_xfer_c = xfer_c & (op_q == DOWN);
    assign h_xfer_c    = xfer_c & (op_q != DOWN);

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_op    = op_q;

    // Both directions held cancel out and restart DAS on each side.
    move_das #(.DAS_TICKS(DAS_TICKS)) u_das_left (
        .clk    (clk),
        .rst    (rst),
        .clr    (~ticking),
        .sample (horizontal_flag),
        .held   (btn_left & ~btn_right),
        .fire_c (left_fire_c)
    );

    move_das #(.DAS_TICKS(DAS_TICKS)) u_das_right (
        .clk    (clk),
        .rst    (rst),
        .clr    (~ticking),
        .sample (horizontal_flag),
        .held   (btn_right & ~btn_left),
        .fire_c (right_fire_c)
    );

    // Sample priority, lowest first so later lines override: SOFT < RIGHT/LEFT < ROT.
    always_comb begin
        sample_op_c = NOP;
        if (soft_req_c)            sample_op_c = SOFT;
        if (right_fire_c)          sample_op_c = RIGHT;
        if (left_fire_c)           sample_op_c = LEFT;
        if (btn_rot && !rot_prev)  sample_op_c = ROT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            op_q       <= NOP;
            lock_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            lock_pulse <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        op_d    = op_q;
        lock_d  = xfer_c & cmd.cmd_blocked & is_drop(op_q);
        case (state_q)
            IDLE: begin
                if (ticking && v_pend) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    op_d    = DOWN;
                end else if (ticking && h_pend) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    op_d    = h_op;
                end
            end
            ISSUE: begin
                if (xfer_c) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    op_d    = NOP;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                op_d    = NOP;
            end
        endcase
    end

    // Pending requests; a new flag in the serving cycle re-arms instead of overrunning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_pend   <= 1'b0;
            h_pend   <= 1'b0;
            h_op     <= NOP;
            rot_prev <= 1'b0;
            overrun  <= 1'b0;
        end else if (!ticking) begin
            v_pend   <= 1'b0;
            h_pend   <= 1'b0;
            rot_prev <= 1'b0;
        end else begin
            if (vertical_flag) begin
                v_pend <= 1'b1;
                if (v_pend && !down_xfer_c) overrun <= 1'b1;
            end else if (down_xfer_c) begin
                v_pend <= 1'b0;
            end
            if (horizontal_flag) rot_prev <= btn_rot;
            if (horizontal_flag && (sample_op_c != NOP)) begin
                h_pend <= 1'b1;
                h_op   <= sample_op_c;
            end else if (h_xfer_c) begin
                h_pend <= 1'b0;
            end
        end
    end
endmodule
